// File: rtl/dma_seq_pkg.sv
// Shared definitions for the DMA descriptor sequencer: state encoding,
// DMA register addresses, START command codes and the run-wait timeout.
package dma_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_W_IO      = 3'd1,
    S_W_MEM     = 3'd2,
    S_W_CNT     = 3'd3,
    S_W_START   = 3'd4,
    S_WAIT_RUN  = 3'd5,
    S_WAIT_DONE = 3'd6
  } seq_state_t;

  localparam logic [13:0] ADR_START = 14'h3FF0;
  localparam logic [13:0] ADR_IOSTR = 14'h3FF1;
  localparam logic [13:0] ADR_MESTR = 14'h3FF2;
  localparam logic [13:0] ADR_DCNTR = 14'h3FF3;

  localparam logic [1:0] START_IO2MEM = 2'b01;
  localparam logic [1:0] START_MEM2IO = 2'b10;

  // Cycles spent in WAIT_RUN before a DMA that never starts is written off
  localparam int unsigned RUN_TIMEOUT = 2;

  function automatic logic [1:0] start_code(input logic dir);
    return dir ? START_MEM2IO : START_IO2MEM;
  endfunction

endpackage

// File: rtl/dma_seq_fifo.sv
// Descriptor FIFO: synchronous, wrap-bit pointers, exact level output and a
// synchronous clear. A push while full is taken when a pop frees the slot.
module dma_seq_fifo
  import dma_seq_pkg::*;
#(
  parameter int WIDTH  = 48,
  parameter int QDEPTH = 4,
  parameter int QAW    = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [QAW:0]     level
);

  localparam logic [QAW:0] PTR_ONE = (QAW+1)'(1);

  logic [WIDTH-1:0] mem [QDEPTH];
  logic [QAW:0]     wr_ptr;
  logic [QAW:0]     rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign level   = wr_ptr - rd_ptr;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[QAW] != rd_ptr[QAW]) &&
                   (wr_ptr[QAW-1:0] == rd_ptr[QAW-1:0]);
  assign do_pop  = pop && !empty && !clr;
  assign do_push = push && (!full || do_pop) && !clr;
  assign rdata   = mem[rd_ptr[QAW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[QAW-1:0]] <= wdata;
  end

endmodule

// File: rtl/dma_seq.sv
// Descriptor sequencer and register-port arbiter in front of the DMA write port.
// Optional completion interrupt (irq / irq_clr) is built with DMA_SEQ_IRQ_EN.
//
// state       | meaning
// S_IDLE      | wait for a queued descriptor and an idle DMA
// S_W_IO      | write IOSTR from the FIFO head
// S_W_MEM     | write MESTR from the FIFO head
// S_W_CNT     | write DCNTR from the FIFO head
// S_W_START   | write START, pop the head
// S_WAIT_RUN  | wait for the DMA to report run (bounded)
// S_WAIT_DONE | wait for run to drop, then pulse done
module dma_seq
  import dma_seq_pkg::*;
#(
  parameter int DWIDTH = 14,
  parameter int QDEPTH = 4,
  parameter int QAW    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rst_pipe,
  input  logic              desc_valid,
  output logic              desc_ready,
  input  logic              desc_dir,
  input  logic [17:0]       desc_io_adr,
  input  logic [DWIDTH-1:0] desc_mem_adr,
  input  logic [DWIDTH:0]   desc_cnt,
  input  logic              cpu_io_we,
  input  logic [13:0]       cpu_io_wadr,
  input  logic [31:0]       cpu_io_wdata,
  output logic              dma_io_we,
  output logic [13:0]       dma_io_wadr,
  output logic [31:0]       dma_io_wdata,
  input  logic [1:0]        dma_run,
  output logic              seq_busy,
  output logic [QAW:0]      q_level,
  output logic              done_pulse
`ifdef DMA_SEQ_IRQ_EN
  ,
  output logic              irq,
  input  logic              irq_clr
`endif
);

  localparam int          FW       = 1 + 18 + DWIDTH + DWIDTH + 1;
  localparam logic [1:0]  TMR_LOAD = 2'(RUN_TIMEOUT - 1);

  seq_state_t        state_q, state_d;
  logic [1:0]        run_tmr;
  logic [FW-1:0]     fifo_rdata;
  logic              fifo_full, fifo_empty, fifo_pop;
  logic              hd_dir;
  logic [17:0]       hd_io;
  logic [DWIDTH-1:0] hd_mem;
  logic [DWIDTH:0]   hd_cnt;
  logic              seq_we;
  logic [13:0]       seq_adr;
  logic [31:0]       seq_wdata;

  dma_seq_fifo #(
    .WIDTH  (FW),
    .QDEPTH (QDEPTH),
    .QAW    (QAW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (rst_pipe),
    .push  (desc_valid),
    .pop   (fifo_pop),
    .wdata ({desc_dir, desc_io_adr, desc_mem_adr, desc_cnt}),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (q_level)
  );

  assign {hd_dir, hd_io, hd_mem, hd_cnt} = fifo_rdata;

  assign desc_ready = !fifo_full || fifo_pop;
  assign seq_busy   = (state_q != S_IDLE) || !fifo_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        state_q <= S_IDLE;
    else if (rst_pipe) state_q <= S_IDLE;
    else               state_q <= state_d;
  end

  // Run-wait timer reloads whenever the FSM is outside WAIT_RUN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     run_tmr <= TMR_LOAD;
    else if (state_q != S_WAIT_RUN) run_tmr <= TMR_LOAD;
    else if (run_tmr != 2'd0)       run_tmr <= run_tmr - 2'd1;
  end

  always_comb begin
    state_d    = state_q;
    seq_we     = 1'b0;
    seq_adr    = '0;
    seq_wdata  = '0;
    fifo_pop   = 1'b0;
    done_pulse = 1'b0;
    if (!rst_pipe) begin
      case (state_q)
        S_IDLE: begin
          if (!fifo_empty && dma_run == 2'b00) begin
            if (hd_cnt == '0) begin
              fifo_pop   = 1'b1;
              done_pulse = 1'b1;
            end else begin
              state_d = S_W_IO;
            end
          end
        end
        S_W_IO: begin
          seq_we    = 1'b1;
          seq_adr   = ADR_IOSTR;
          seq_wdata = {12'd0, hd_io, 2'b00};
          if (!cpu_io_we) state_d = S_W_MEM;
        end
        S_W_MEM: begin
          seq_we    = 1'b1;
          seq_adr   = ADR_MESTR;
          seq_wdata = 32'({hd_mem, 2'b00});
          if (!cpu_io_we) state_d = S_W_CNT;
        end
        S_W_CNT: begin
          seq_we    = 1'b1;
          seq_adr   = ADR_DCNTR;
          seq_wdata = 32'(hd_cnt);
          if (!cpu_io_we) state_d = S_W_START;
        end
        S_W_START: begin
          seq_we    = 1'b1;
          seq_adr   = ADR_START;
          seq_wdata = {30'd0, start_code(hd_dir)};
          if (!cpu_io_we) begin
            fifo_pop = 1'b1;
            state_d  = S_WAIT_RUN;
          end
        end
        S_WAIT_RUN: begin
          if (dma_run != 2'b00) begin
            state_d = S_WAIT_DONE;
          end else if (run_tmr == 2'd0) begin
            done_pulse = 1'b1;
            state_d    = S_IDLE;
          end
        end
        S_WAIT_DONE: begin
          if (dma_run == 2'b00) begin
            done_pulse = 1'b1;
            state_d    = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // CPU always owns the port when it writes; sequencer fills idle cycles
  always_comb begin
    dma_io_we    = 1'b0;
    dma_io_wadr  = '0;
    dma_io_wdata = '0;
    if (cpu_io_we) begin
      dma_io_we    = 1'b1;
      dma_io_wadr  = cpu_io_wadr;
      dma_io_wdata = cpu_io_wdata;
    end else if (seq_we) begin
      dma_io_we    = 1'b1;
      dma_io_wadr  = seq_adr;
      dma_io_wdata = seq_wdata;
    end
  end

`ifdef DMA_SEQ_IRQ_EN
  logic push_acc;
  logic irq_set;

  assign push_acc = desc_valid && desc_ready && !rst_pipe;
  assign irq_set  = done_pulse && !push_acc && (q_level == (QAW+1)'(fifo_pop));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    irq <= 1'b0;
    else if (rst_pipe || irq_clr)  irq <= 1'b0;
    else if (irq_set)              irq <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_dma_seq.sv
// Scoreboard bench for dma_seq: expected register writes and done pulses are
// queued at push time and consumed by a negedge monitor that also models the DMA.
module tb_dma_seq;

  localparam int DW = 14;
  localparam int QD = 4;
  localparam int QA = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rst_pipe = 1'b0;
  logic          desc_valid = 1'b0;
  logic          desc_ready;
  logic          desc_dir = 1'b0;
  logic [17:0]   desc_io_adr = '0;
  logic [DW-1:0] desc_mem_adr = '0;
  logic [DW:0]   desc_cnt = '0;
  logic          cpu_io_we = 1'b0;
  logic [13:0]   cpu_io_wadr = '0;
  logic [31:0]   cpu_io_wdata = '0;
  logic          dma_io_we;
  logic [13:0]   dma_io_wadr;
  logic [31:0]   dma_io_wdata;
  logic [1:0]    dma_run = 2'b00;
  logic          seq_busy;
  logic [QA:0]   q_level;
  logic          done_pulse;
`ifdef DMA_SEQ_IRQ_EN
  logic          irq;
  logic          irq_clr = 1'b0;
`endif

  typedef struct {
    logic [13:0] adr;
    logic [31:0] data;
  } wr_t;

  int   vectors = 0;
  int   miscompares = 0;
  wr_t  exp_wr[$];
  int   exp_done = 0;
  int   seq_wr_cyc[$];
  int   done_cyc[$];
  int   cyc = 0;
  wr_t  mon_e;
  logic [1:0] force_run = 2'b00;
  int   run_len = 4;
  int   run_left = 0;
  bit   dma_mute = 1'b0;

  dma_seq #(.DWIDTH(DW), .QDEPTH(QD), .QAW(QA)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rst_pipe     (rst_pipe),
    .desc_valid   (desc_valid),
    .desc_ready   (desc_ready),
    .desc_dir     (desc_dir),
    .desc_io_adr  (desc_io_adr),
    .desc_mem_adr (desc_mem_adr),
    .desc_cnt     (desc_cnt),
    .cpu_io_we    (cpu_io_we),
    .cpu_io_wadr  (cpu_io_wadr),
    .cpu_io_wdata (cpu_io_wdata),
    .dma_io_we    (dma_io_we),
    .dma_io_wadr  (dma_io_wadr),
    .dma_io_wdata (dma_io_wdata),
    .dma_run      (dma_run),
    .seq_busy     (seq_busy),
    .q_level      (q_level),
    .done_pulse   (done_pulse)
`ifdef DMA_SEQ_IRQ_EN
    ,
    .irq          (irq),
    .irq_clr      (irq_clr)
`endif
  );

  always #5 clk = ~clk;

  // Monitor: checks the port every cycle and plays the DMA run handshake
  initial begin : monitor
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_pipe) run_left = 0;
      if (cpu_io_we) begin
        vectors++;
        if (dma_io_we !== 1'b1 || dma_io_wadr !== cpu_io_wadr || dma_io_wdata !== cpu_io_wdata) begin
          miscompares++;
          $display("FAIL cpu_pass cyc %0d: got we=%b %h/%h, required we=1 %h/%h",
                   cyc, dma_io_we, dma_io_wadr, dma_io_wdata, cpu_io_wadr, cpu_io_wdata);
        end
      end else if (dma_io_we === 1'b1) begin
        seq_wr_cyc.push_back(cyc);
        vectors++;
        if (exp_wr.size() == 0) begin
          miscompares++;
          $display("FAIL seq_wr cyc %0d: got unexpected write %h=%h, required none",
                   cyc, dma_io_wadr, dma_io_wdata);
        end else begin
          mon_e = exp_wr.pop_front();
          if (dma_io_wadr !== mon_e.adr || dma_io_wdata !== mon_e.data) begin
            miscompares++;
            $display("FAIL seq_wr cyc %0d: got %h=%h, required %h=%h",
                     cyc, dma_io_wadr, dma_io_wdata, mon_e.adr, mon_e.data);
          end
        end
        if (dma_io_wadr == 14'h3FF0 && !dma_mute && !rst_pipe) run_left = run_len;
      end else begin
        vectors++;
        if (dma_io_we !== 1'b0 || dma_io_wadr !== 14'd0 || dma_io_wdata !== 32'd0) begin
          miscompares++;
          $display("FAIL idle_port cyc %0d: got we=%b %h/%h, required 0 0/0",
                   cyc, dma_io_we, dma_io_wadr, dma_io_wdata);
        end
      end
      if (done_pulse === 1'b1) begin
        done_cyc.push_back(cyc);
        vectors++;
        if (exp_done == 0) begin
          miscompares++;
          $display("FAIL done cyc %0d: got unexpected done_pulse, required none", cyc);
        end else begin
          exp_done--;
        end
      end
      @(posedge clk);
      #2;
      if (run_left > 0) run_left--;
      dma_run = force_run | ((run_left > 0) ? 2'b01 : 2'b00);
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_desc(input logic dir, input logic [17:0] io, input logic [DW-1:0] mem,
                           input logic [DW:0] cnt, input int budget, output int acc_cyc);
    bit ok;
    wr_t e;
    ok = 1'b0;
    acc_cyc = -1;
    desc_valid = 1'b1;
    desc_dir = dir;
    desc_io_adr = io;
    desc_mem_adr = mem;
    desc_cnt = cnt;
    for (int i = 0; i < budget && !ok; i++) begin
      acc_cyc = cyc + 1;
      @(negedge clk);
      ok = (desc_ready === 1'b1);
      step();
    end
    desc_valid = 1'b0;
    if (ok) begin
      if (cnt != '0) begin
        e.adr = 14'h3FF1; e.data = 32'(io) << 2;       exp_wr.push_back(e);
        e.adr = 14'h3FF2; e.data = 32'(mem) << 2;      exp_wr.push_back(e);
        e.adr = 14'h3FF3; e.data = 32'(cnt);           exp_wr.push_back(e);
        e.adr = 14'h3FF0; e.data = dir ? 32'd2 : 32'd1; exp_wr.push_back(e);
      end
      exp_done++;
    end else begin
      vectors++;
      miscompares++;
      $display("FAIL push_timeout: desc_ready low for %0d cycles, required accept", budget);
    end
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while ((exp_wr.size() != 0 || exp_done != 0 || seq_busy !== 1'b0) && n < budget) begin
      step();
      n++;
    end
    vectors++;
    if (n >= budget) begin
      miscompares++;
      $display("FAIL %s_drain: busy after %0d cycles (writes left %0d, dones left %0d), required idle",
               name, budget, exp_wr.size(), exp_done);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (desc_ready !== 1'b1 || q_level !== '0 || seq_busy !== 1'b0 || done_pulse !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_out: got ready=%b lvl=%0d busy=%b done=%b, required 1 0 0 0",
               desc_ready, q_level, seq_busy, done_pulse);
    end
    vectors++;
    if (dma_io_we !== 1'b0 || dma_io_wadr !== 14'd0 || dma_io_wdata !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_port: got we=%b %h/%h, required 0 0/0", dma_io_we, dma_io_wadr, dma_io_wdata);
    end
`ifdef DMA_SEQ_IRQ_EN
    vectors++;
    if (irq !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_irq: got %b, required 0", irq);
    end
`endif
    rst_n = 1'b1;
    step();
  endtask

  task automatic check_cyc(input string name, input int got, input int want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got cycle %0d, required cycle %0d", name, got, want);
    end
  endtask

  task automatic test_single();
    int t0, n0, d0;
    n0 = seq_wr_cyc.size();
    d0 = done_cyc.size();
    push_desc(1'b0, 18'h100, 14'h20, 15'd8, 10, t0);
    wait_idle("single", 40);
    vectors++;
    if (seq_wr_cyc.size() != n0 + 4 || done_cyc.size() != d0 + 1) begin
      miscompares++;
      $display("FAIL single_count: got %0d writes %0d dones, required 4 1",
               seq_wr_cyc.size() - n0, done_cyc.size() - d0);
    end else begin
      for (int i = 0; i < 4; i++) check_cyc("single_wr_cyc", seq_wr_cyc[n0+i], t0 + 2 + i);
      check_cyc("single_done_cyc", done_cyc[d0], t0 + 9);
    end
  endtask

  task automatic test_cpu_collision();
    int t0, n0;
    n0 = seq_wr_cyc.size();
    push_desc(1'b0, 18'h100, 14'h20, 15'd8, 10, t0);
    for (int c = t0 + 1; c <= t0 + 8; c++) begin
      cpu_io_we = (c == t0 + 3) || (c == t0 + 4);
      cpu_io_wadr = 14'h0100 + 14'(c);
      cpu_io_wdata = 32'hC0DE_0000 ^ 32'(c);
      step();
    end
    cpu_io_we = 1'b0;
    cpu_io_wadr = '0;
    cpu_io_wdata = '0;
    wait_idle("collision", 40);
    vectors++;
    if (seq_wr_cyc.size() != n0 + 4) begin
      miscompares++;
      $display("FAIL collision_count: got %0d writes, required 4", seq_wr_cyc.size() - n0);
    end else begin
      check_cyc("collision_io", seq_wr_cyc[n0], t0 + 2);
      check_cyc("collision_mem", seq_wr_cyc[n0+1], t0 + 5);
      check_cyc("collision_cnt", seq_wr_cyc[n0+2], t0 + 6);
      check_cyc("collision_start", seq_wr_cyc[n0+3], t0 + 7);
    end
  endtask

  task automatic test_back_to_back();
    int acc[5];
    int d0;
    d0 = done_cyc.size();
    for (int i = 0; i < 5; i++) begin
      push_desc(1'(i & 1), 18'h3_0000 + 18'(i * 7), 14'h3FF0 - 14'(i), 15'd100 + 15'(i), 20, acc[i]);
      if (i == 3) begin
        vectors++;
        if (q_level !== 3'd4 || desc_ready !== 1'b0) begin
          miscompares++;
          $display("FAIL b2b_full: got level=%0d ready=%b, required 4 0", q_level, desc_ready);
        end
      end
    end
    for (int i = 1; i < 4; i++) check_cyc("b2b_accept", acc[i], acc[0] + i);
    check_cyc("b2b_fifth_accept", acc[4], acc[0] + 5);
    wait_idle("b2b", 200);
    vectors++;
    if (done_cyc.size() != d0 + 5) begin
      miscompares++;
      $display("FAIL b2b_dones: got %0d done pulses, required 5", done_cyc.size() - d0);
    end
  endtask

  task automatic test_cnt_zero();
    int t0, n0, d0;
    n0 = seq_wr_cyc.size();
    d0 = done_cyc.size();
    push_desc(1'b1, 18'h2_AAAA, 14'h1555, 15'd0, 10, t0);
    wait_idle("cnt0", 20);
    vectors++;
    if (seq_wr_cyc.size() != n0 || done_cyc.size() != d0 + 1) begin
      miscompares++;
      $display("FAIL cnt0_count: got %0d writes %0d dones, required 0 1",
               seq_wr_cyc.size() - n0, done_cyc.size() - d0);
    end else begin
      check_cyc("cnt0_done_cyc", done_cyc[d0], t0 + 1);
    end
  endtask

  task automatic test_run_held();
    int t0, n0, r;
    n0 = seq_wr_cyc.size();
    force_run = 2'b10;
    step();
    push_desc(1'b1, 18'h0_0003, 14'h0007, 15'h7FFF, 10, t0);
    repeat (5) step();
    vectors++;
    if (seq_wr_cyc.size() != n0 || seq_busy !== 1'b1 || q_level !== 3'd1) begin
      miscompares++;
      $display("FAIL run_held: got %0d writes busy=%b lvl=%0d, required 0 1 1",
               seq_wr_cyc.size() - n0, seq_busy, q_level);
    end
    r = cyc + 1;
    force_run = 2'b00;
    wait_idle("run_held", 40);
    vectors++;
    if (seq_wr_cyc.size() != n0 + 4) begin
      miscompares++;
      $display("FAIL run_held_count: got %0d writes, required 4", seq_wr_cyc.size() - n0);
    end else begin
      check_cyc("run_held_first_wr", seq_wr_cyc[n0], r + 1);
    end
  endtask

  task automatic test_timeout();
    int t0, d0;
    d0 = done_cyc.size();
    dma_mute = 1'b1;
    push_desc(1'b0, 18'h0_1234, 14'h0100, 15'd5, 10, t0);
    wait_idle("timeout", 30);
    dma_mute = 1'b0;
    vectors++;
    if (done_cyc.size() != d0 + 1) begin
      miscompares++;
      $display("FAIL timeout_count: got %0d dones, required 1", done_cyc.size() - d0);
    end else begin
      check_cyc("timeout_done_cyc", done_cyc[d0], t0 + 7);
    end
  endtask

  task automatic test_rst_pipe();
    int t0, t1, t2, n0;
    run_len = 12;
    push_desc(1'b0, 18'h0_0010, 14'h0020, 15'd16, 10, t0);
    push_desc(1'b1, 18'h0_0011, 14'h0021, 15'd17, 10, t1);
    push_desc(1'b0, 18'h0_0012, 14'h0022, 15'd18, 10, t2);
    repeat (5) step();
    rst_pipe = 1'b1;
    exp_wr.delete();
    exp_done = 0;
    step();
    rst_pipe = 1'b0;
    n0 = seq_wr_cyc.size();
    vectors++;
    if (q_level !== '0 || seq_busy !== 1'b0 || desc_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_pipe_state: got lvl=%0d busy=%b ready=%b, required 0 0 1",
               q_level, seq_busy, desc_ready);
    end
`ifdef DMA_SEQ_IRQ_EN
    vectors++;
    if (irq !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_pipe_irq: got %b, required 0", irq);
    end
`endif
    repeat (15) step();
    vectors++;
    if (seq_wr_cyc.size() != n0) begin
      miscompares++;
      $display("FAIL rst_pipe_quiet: got %0d writes, required 0", seq_wr_cyc.size() - n0);
    end
    run_len = 4;
  endtask

`ifdef DMA_SEQ_IRQ_EN
  task automatic test_irq();
    int t0, t1, n;
    push_desc(1'b0, 18'h0_0040, 14'h0050, 15'd3, 10, t0);
    push_desc(1'b1, 18'h0_0041, 14'h0051, 15'd4, 10, t1);
    n = 0;
    while (exp_done > 1 && n < 40) begin
      step();
      n++;
    end
    vectors++;
    if (n >= 40 || irq !== 1'b0) begin
      miscompares++;
      $display("FAIL irq_mid: got irq=%b after %0d cycles, required 0 after first done", irq, n);
    end
    wait_idle("irq", 40);
    vectors++;
    if (irq !== 1'b1) begin
      miscompares++;
      $display("FAIL irq_set: got %b, required 1", irq);
    end
    irq_clr = 1'b1;
    step();
    irq_clr = 1'b0;
    vectors++;
    if (irq !== 1'b0) begin
      miscompares++;
      $display("FAIL irq_clr: got %b, required 0", irq);
    end
  endtask
`endif

  initial begin : main
    test_reset();
    test_single();
    test_cpu_collision();
    test_back_to_back();
    test_cnt_zero();
    test_run_held();
    test_timeout();
    test_rst_pipe();
`ifdef DMA_SEQ_IRQ_EN
    test_irq();
`endif
    repeat (3) step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
